// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Result-collection stage behind a 4-bit full adder. Each accepted word
// {Cout, Sum} (0..31) is added into a saturating ACC_W-bit total. After
// COUNT_N words, the total is held on a registered output handshake until
// the consumer takes it.
//
// Parameters
//   ACC_W    accumulator width in bits (>= 5)
//   COUNT_N  words summed per batch (>= 1)
//   CNT_W    sample counter width
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   clear       synchronous batch abort (same effect as reset)
//   in_valid    adder result present this cycle
//   in_ready    block accepts a word this cycle (combinational)
//   Sum, Cout   adder result word
//   acc_out     accumulated total (registered)
//   acc_valid   batch complete, acc_out is final (registered)
//   out_ready   consumer takes the finished total
//   overflow    sticky saturation flag for the current batch (registered)
//   sample_cnt  words accepted in the current batch (registered)
//
// Handshake semantics: a word transfers on a rising edge where
// in_valid & in_ready are both high. in_ready never depends on in_valid.
// The finished total is released on a rising edge where acc_valid and
// out_ready are both high; acc_out stays stable while acc_valid is high.
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int ACC_W   = 8,
    parameter int COUNT_N = 10,
    parameter int CNT_W   = $clog2(COUNT_N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Sum,
    input  logic             Cout,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    logic             xfer;
    logic [ACC_W:0]   sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             last_word;

    // The result word is zero-extended to one bit wider than the total so
    // the top bit of sum_next is the saturation indicator.
    assign sum_next  = {1'b0, acc_out} + (ACC_W + 1)'({Cout, Sum});
    assign cnt_next  = sample_cnt + CNT_W'(1);
    assign last_word = (cnt_next == CNT_W'(COUNT_N));

    // No acceptance during reset/clear, and none while a total is held.
    assign in_ready = rst_n & ~clear & (state != DONE);
    assign xfer     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state      <= IDLE;
            acc_out    <= '0;
            acc_valid  <= 1'b0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            case (state)
                DONE: begin
                    // Release zeroes the batch; there is no bypass, so the
                    // next word can only be taken from the following cycle.
                    if (out_ready) begin
                        state      <= IDLE;
                        acc_out    <= '0;
                        acc_valid  <= 1'b0;
                        overflow   <= 1'b0;
                        sample_cnt <= '0;
                    end
                end
                default: begin
                    if (xfer) begin
                        if (sum_next[ACC_W]) begin
                            acc_out  <= '1;
                            overflow <= 1'b1;
                        end else begin
                            acc_out <= sum_next[ACC_W-1:0];
                        end
                        sample_cnt <= cnt_next;
                        if (last_word) begin
                            state     <= DONE;
                            acc_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Directed, table-driven bench for sum_accumulator (ACC_W = 8, COUNT_N = 10).
// Each table row is one clock cycle: the inputs driven during the cycle,
// the expected in_ready before the edge, and the expected registered
// outputs after the edge. Batch totals are also checked against a queue
// of expected totals whenever acc_valid rises.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int ACC_W   = 8;
    localparam int COUNT_N = 10;
    localparam int CNT_W   = $clog2(COUNT_N + 1);

    typedef struct {
        logic       rst_n;
        logic       clear;
        logic       in_valid;
        logic [4:0] w;
        logic       out_ready;
        logic       e_rdy;
        int         e_acc;
        int         e_cnt;
        logic       e_av;
        logic       e_ovf;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Sum;
    logic             Cout;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             out_ready;
    logic             overflow;
    logic [CNT_W-1:0] sample_cnt;

    vec_t             vecs[$];
    logic [ACC_W-1:0] exp_q[$];
    int               tests_run;
    int               tests_failed;
    logic             prev_av;

    sum_accumulator #(
        .ACC_W   (ACC_W),
        .COUNT_N (COUNT_N),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Sum        (Sum),
        .Cout       (Cout),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .sample_cnt (sample_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic c, input logic v,
                       input int w, input logic o, input logic e_rdy,
                       input int e_acc, input int e_cnt, input logic e_av,
                       input logic e_ovf);
        vec_t x;
        x.rst_n     = r;
        x.clear     = c;
        x.in_valid  = v;
        x.w         = 5'(w);
        x.out_ready = o;
        x.e_rdy     = e_rdy;
        x.e_acc     = e_acc;
        x.e_cnt     = e_cnt;
        x.e_av      = e_av;
        x.e_ovf     = e_ovf;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int step, input int act,
                       input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL step %0d %s: got %0d expected %0d", step, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst_n     = x.rst_n;
        clear     = x.clear;
        in_valid  = x.in_valid;
        Cout      = x.w[4];
        Sum       = x.w[3:0];
        out_ready = x.out_ready;
    endtask

    task automatic build_table();
        // 1. Reset held 2 cycles with a word offered, then release.
        add(0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 2. Basic batch: ten words of 5.
        for (int i = 0; i < 10; i++)
            add(1, 0, 1, 5, 0, 1, 5 * (i + 1), i + 1, i == 9, 0);
        exp_q.push_back(8'd50);
        add(1, 0, 0, 0, 0, 0, 50, 10, 1, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // 3. Saturation: ten words of 31 ({1, 4'hF}); the 9th saturates.
        for (int i = 0; i < 10; i++) begin
            if (i < 8)
                add(1, 0, 1, 31, 0, 1, 31 * (i + 1), i + 1, 0, 0);
            else
                add(1, 0, 1, 31, 0, 1, 255, i + 1, i == 9, 1);
        end
        exp_q.push_back(8'd255);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 4. Batch of ten 20s ({1, 4'h4}), then backpressure in DONE.
        for (int i = 0; i < 10; i++)
            add(1, 0, 1, 20, 0, 1, 20 * (i + 1), i + 1, i == 9, 0);
        exp_q.push_back(8'd200);
        for (int i = 0; i < 5; i++)
            add(1, 0, 1, 7, 0, 0, 200, 10, 1, 0);
        // Release cycle: the offered 7 must be dropped.
        add(1, 0, 1, 7, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 2, 0, 1, 2, 1, 0, 0);
        add(1, 0, 1, 3, 0, 1, 5, 2, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // 5. Gapped input 1, 2, 3 then clear with a 9 offered.
        add(1, 0, 1, 1, 0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        add(1, 0, 1, 2, 0, 1, 3, 2, 0, 0);
        add(1, 0, 0, 0, 0, 1, 3, 2, 0, 0);
        add(1, 0, 0, 0, 0, 1, 3, 2, 0, 0);
        add(1, 0, 1, 3, 0, 1, 6, 3, 0, 0);
        add(1, 1, 1, 9, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 6. Seven words, reset mid-batch, then ten words of 1 with
        //    out_ready held high (no effect outside DONE).
        for (int i = 0; i < 7; i++)
            add(1, 0, 1, 1, 0, 1, i + 1, i + 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(1, 0, 1, 1, 1, 1, i + 1, i + 1, i == 9, 0);
        exp_q.push_back(8'd10);
        add(1, 0, 1, 4, 0, 0, 10, 10, 1, 0);
        // Clear while a total is held.
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 4, 0, 1, 4, 1, 0, 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        prev_av      = 1'b0;
        rst_n        = 1'b0;
        clear        = 1'b0;
        in_valid     = 1'b0;
        Sum          = 4'd0;
        Cout         = 1'b0;
        out_ready    = 1'b0;

        build_table();

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("in_ready", i, int'(in_ready), int'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk("acc_out", i, int'(acc_out), vecs[i].e_acc);
            chk("sample_cnt", i, int'(sample_cnt), vecs[i].e_cnt);
            chk("acc_valid", i, int'(acc_valid), int'(vecs[i].e_av));
            chk("overflow", i, int'(overflow), int'(vecs[i].e_ovf));
            // Scoreboard: each rising acc_valid delivers the next total.
            if (acc_valid && !prev_av) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_batch", i, 1, 0);
                end else begin
                    chk("batch_total", i, int'(acc_out), int'(exp_q.pop_front()));
                end
            end
            prev_av = acc_valid;
        end

        chk("batches_left", vecs.size(), exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 4-bit full adder. Each cycle it takes one adder result word `{Cout, Sum}` through a valid/ready handshake. It accumulates `COUNT_N` results into a saturating `ACC_W`-bit total, then presents the total on a held output handshake. Typical use is as the result-collection stage behind the adder in a multi-sample datapath or self-checking harness.

## Interface
- `ACC_W`, 8: accumulator width in bits; must be ≥ 5.
- `COUNT_N`, 10: number of adder results summed per batch; must be ≥ 1.
- `CNT_W`, `$clog2(COUNT_N+1)`: width of the sample counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clear`  in  1  synchronous batch abort; same effect as reset.
- `in_valid`  in  1  adder result present this cycle.
- `in_ready`  out  1  block accepts a word this cycle (combinational).
- `Sum`  in  4  adder sum.
- `Cout`  in  1  adder carry-out.
- `acc_out`  out  `ACC_W`  accumulated total (registered).
- `acc_valid`  out  1  batch complete; `acc_out` is final (registered).
- `out_ready`  in  1  consumer takes the finished total.
- `overflow`  out  1  sticky: saturation occurred in the current batch (registered).
- `sample_cnt`  out  `CNT_W`  words accepted in the current batch (registered).

## Operation
- Input word `w = {Cout, Sum}`: 5-bit unsigned, range 0..31. It is zero-extended to `ACC_W + 1` bits for the add.
- States:
  - `IDLE`: empty batch; `acc_out` = 0 and `sample_cnt` = 0.
  - `ACCUM`: partial batch in progress.
  - `DONE`: result held for the consumer.
- `in_ready = rst_n & ~clear & (state != DONE)`.
- A transfer occurs when `in_valid & in_ready`.
- On a transfer in `IDLE` or `ACCUM`:
  - `sum_next = acc_out + w`.
  - If `sum_next > 2^ACC_W − 1`: `acc_out` ← all ones and `overflow` ← 1.
  - Otherwise `acc_out` ← `sum_next`.
  - `sample_cnt` increments.
- State transitions:
  - `IDLE` → `ACCUM` on the first transfer.
  - `ACCUM`/`IDLE` → `DONE` on the transfer that brings `sample_cnt` to `COUNT_N`. With `COUNT_N` = 1, `IDLE` goes directly to `DONE`.
  - `DONE` → `IDLE` when `out_ready` = 1. On that edge `acc_out`, `sample_cnt` and `overflow` clear to 0.
- `acc_valid` = 1 exactly while in `DONE`.
- In `DONE`, the outputs are frozen. `in_valid` is ignored (`in_ready` = 0).
- Once set, `overflow` stays set until the batch is released, cleared or reset. Further adds keep `acc_out` at all ones.
- Any cycle without a transfer leaves the accumulator and counter unchanged. Gaps in `in_valid` are allowed.
- Priority, highest first: `rst_n` low, then `clear`, then the `DONE` release, then accumulation.
- `clear` or reset in any state returns the block to `IDLE` with all outputs zeroed. An `in_valid` word in that cycle is dropped and not counted.

## Timing
- Reset values: `acc_out` = 0, `acc_valid` = 0, `overflow` = 0, `sample_cnt` = 0, state = `IDLE`.
  - `in_ready` = 0 while `rst_n` is low.
  - `in_ready` = 1 in the first cycle after release, if `clear` = 0.
- Accumulate latency: 1 cycle. Transfer at edge k updates `acc_out` and `sample_cnt` visible after edge k.
- Throughput: 1 word per cycle in `IDLE`/`ACCUM`.
- `acc_valid` rises after the edge that captures the `COUNT_N`-th word. Minimum batch time is `COUNT_N` cycles.
- Release: `out_ready` sampled high at edge m while `acc_valid` = 1.
  - `acc_valid` falls after edge m.
  - `in_ready` = 1 in the cycle after edge m.
  - There is no same-cycle bypass: a word offered during the release cycle is not accepted.
- `out_ready` high outside `DONE` has no effect.

## Test plan
1. **Reset.** Hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 and `w` = 7.
   - Required: `acc_out` = 0, `acc_valid` = 0, `overflow` = 0, `sample_cnt` = 0, `in_ready` = 0.
   - After release: `in_ready` = 1.
2. **Basic batch.** Send 10 back-to-back words `{0, 4'd5}`, with `out_ready` = 0.
   - Required: `acc_out` = 50, `sample_cnt` = 10, `acc_valid` = 1 one cycle after the 10th transfer, `overflow` = 0.
   - Words with `Cout` = 1 (e.g. `{1, 4'hF}` = 31) must add 31 each.
3. **Saturation.** Send 10 words of 31.
   - After word 9, 279 would exceed 255, so `acc_out` = 255 and `overflow` = 1.
   - `acc_out` stays 255 at `DONE`.
   - After the release, `overflow` = 0.
4. **Backpressure in `DONE`.** Hold `out_ready` = 0 for 5 cycles with `in_valid` = 1.
   - Required: `in_ready` = 0 and all outputs frozen.
   - Then pulse `out_ready` for 1 cycle: next cycle `acc_valid` = 0, `acc_out` = 0, `in_ready` = 1.
   - A new batch of `2, 3` then gives `acc_out` = 5.
5. **Gapped input and mid-batch `clear`.**
   - Send words 1, 2, 3 with idle cycles between them: `acc_out` = 6, `sample_cnt` = 3.
   - Assert `clear` with `in_valid` = 1 and `w` = 9: next cycle `acc_out` = 0, `sample_cnt` = 0, and the 9 is not counted.
6. **Reset mid-operation.** After 7 words, drive `rst_n` low for 1 cycle.
   - Required: all outputs zero after that edge.
   - The next 10 words of 1 produce `acc_out` = 10, confirming the counter restarted.
